// File: rtl/q_sys_descriptor_fetch.sv
// Descriptor-chain fetcher: walks a linked list of 4-word descriptors,
// hands each one to a DMA engine and writes back completion status.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   start, start_ptr      - begin a chain at word address start_ptr
//   busy                  - high while a chain is in progress
//   mem_*                 - descriptor memory master (1-cycle read latency)
//   desc_valid/ready,
//   desc_src/dst/len      - descriptor handoff to the DMA engine
//   dma_done, dma_error   - DMA completion pulse and its error status
//   chain_done, chain_stopped, desc_count - chain completion reporting
module q_sys_descriptor_fetch #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_ptr,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [3:0]            mem_byteenable,
    output logic [31:0]           mem_writedata,
    input  logic [31:0]           mem_readdata,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [31:0]           desc_src,
    output logic [31:0]           desc_dst,
    output logic [15:0]           desc_len,
    input  logic                  dma_done,
    input  logic                  dma_error,
    output logic                  chain_done,
    output logic                  chain_stopped,
    output logic [15:0]           desc_count
);

    typedef enum logic [2:0] {
        IDLE, FETCH, CAPTURE, CHECK,
        PRESENT, WAIT_DONE, WRITEBACK, NEXT
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] nxt_ptr;
    logic [1:0]            k;
    logic                  own;
    logic                  eoc;
    logic                  err;

    // Control-word bits between the flags and the length are reserved.
    logic unused_rd;
    assign unused_rd = &{1'b0, mem_readdata[29:16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            nxt_ptr    <= '0;
            k          <= '0;
            own        <= 1'b0;
            eoc        <= 1'b0;
            err        <= 1'b0;
            desc_src   <= '0;
            desc_dst   <= '0;
            desc_len   <= '0;
            desc_count <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    k <= '0;
                    if (start) begin
                        ptr        <= start_ptr;
                        desc_count <= '0;
                    end
                end
                FETCH: begin
                    // Data returned now belongs to the address of k-1.
                    k <= k + 2'd1;
                    unique case (k)
                        2'd1: desc_src <= mem_readdata;
                        2'd2: desc_dst <= mem_readdata;
                        2'd3: begin
                            own      <= mem_readdata[31];
                            eoc      <= mem_readdata[30];
                            desc_len <= mem_readdata[15:0];
                        end
                        default: ;
                    endcase
                end
                CAPTURE:   nxt_ptr <= mem_readdata[ADDR_WIDTH-1:0];
                WAIT_DONE: if (dma_done) err <= dma_error;
                WRITEBACK: begin
                    if (desc_count != 16'hFFFF)
                        desc_count <= desc_count + 16'd1;
                end
                NEXT: begin
                    k <= '0;
                    if (!eoc) ptr <= nxt_ptr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = (state != IDLE);
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'hF;
        mem_writedata  = '0;
        desc_valid     = 1'b0;
        chain_done     = 1'b0;
        chain_stopped  = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = FETCH;
            FETCH: begin
                mem_chipselect = 1'b1;
                mem_address    = ptr + ADDR_WIDTH'(k);
                if (k == 2'd3) state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = CHECK;
            CHECK: begin
                if (own) begin
                    state_nxt = PRESENT;
                end else begin
                    chain_done    = 1'b1;
                    chain_stopped = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            PRESENT: begin
                desc_valid = 1'b1;
                if (desc_ready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (dma_done) state_nxt = WRITEBACK;
            WRITEBACK: begin
                // Only byte 3 is touched: OWN cleared, EOC kept, error set.
                mem_chipselect       = 1'b1;
                mem_write            = 1'b1;
                mem_byteenable       = 4'b1000;
                mem_address          = ptr + ADDR_WIDTH'(2);
                mem_writedata[31:24] = {1'b0, eoc, err, 5'b0};
                state_nxt            = NEXT;
            end
            NEXT: begin
                if (eoc) begin
                    chain_done = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_q_sys_descriptor_fetch.sv
// Directed bench for q_sys_descriptor_fetch with a 1-cycle-latency
// memory model; immediate assertions at each comparison point.
module tb_q_sys_descriptor_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] start_ptr;
    logic        busy;
    logic [10:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_src;
    logic [31:0] desc_dst;
    logic [15:0] desc_len;
    logic        dma_done;
    logic        dma_error;
    logic        chain_done;
    logic        chain_stopped;
    logic [15:0] desc_count;

    int checks = 0;
    int failures = 0;

    bit [31:0]   mem [0:2047];
    logic        ld_en = 1'b0;
    logic [10:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    int          wr_count = 0;
    int          valid_cnt = 0;
    int          fcnt = 0;
    logic [10:0] fa [0:63];

    always #5 clk = ~clk;

    q_sys_descriptor_fetch #(.ADDR_WIDTH(11)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ptr(start_ptr),
        .busy(busy), .mem_address(mem_address),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .desc_valid(desc_valid),
        .desc_ready(desc_ready), .desc_src(desc_src), .desc_dst(desc_dst),
        .desc_len(desc_len), .dma_done(dma_done), .dma_error(dma_error),
        .chain_done(chain_done), .chain_stopped(chain_stopped),
        .desc_count(desc_count)
    );

    always @(posedge clk) begin
        if (desc_valid) valid_cnt <= valid_cnt + 1;
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_chipselect) begin
            if (mem_write) begin
                wr_count <= wr_count + 1;
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= mem[mem_address];
                fa[fcnt % 64] <= mem_address;
                fcnt <= fcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [10:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_for(input string tag, input bit which);
        int n = 0;
        while (!(which ? chain_done : desc_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, (which ? chain_done : desc_valid)}, 32'd1);
    endtask

    task automatic serve(input logic [31:0] esrc, input logic err);
        wait_for("serve_valid", 1'b0);
        chk("serve_src", desc_src, esrc);
        @(negedge clk);
        dma_done = 1'b1; dma_error = err;
        @(negedge clk);
        dma_done = 1'b0; dma_error = 1'b0;
    endtask

    initial begin
        int f0, w0, v0;
        reset = 1'b1; start = 1'b0; start_ptr = '0; desc_ready = 1'b1;
        dma_done = 1'b0; dma_error = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_valid", {31'b0, desc_valid}, 0);
        chk("rst_cs_we", {30'b0, mem_chipselect, mem_write}, 0);
        chk("rst_done", {30'b0, chain_done, chain_stopped}, 0);
        chk("rst_count", {16'b0, desc_count}, 0);
        chk("rst_payload", desc_src | desc_dst | {16'b0, desc_len}, 0);
        chk("rst_be", {28'b0, mem_byteenable}, 32'hF);
        reset = 1'b0;

        load(11'h010, 32'h1000); load(11'h011, 32'h2000);
        load(11'h012, 32'hC000_0040); load(11'h013, 32'h20);
        load(11'h040, 32'hA); load(11'h041, 32'hB);
        load(11'h042, 32'h8000_0008); load(11'h043, 32'h7FE);
        load(11'h7FE, 32'hC); load(11'h7FF, 32'hD);
        load(11'h000, 32'hC000_0004); load(11'h001, 32'h40);
        load(11'h052, 32'h0000_0010);
        load(11'h060, 32'h1111_2222); load(11'h061, 32'h3333_4444);
        load(11'h062, 32'hC000_1234); load(11'h063, 32'h0);

        // Single descriptor, cycle-exact
        start = 1'b1; start_ptr = 11'h010;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_rd", {30'b0, mem_chipselect, mem_write}, 32'b10);
        for (int i = 0; i < 4; i++) begin
            chk("t1_faddr", {21'b0, mem_address}, 32'h10 + i);
            @(negedge clk);
        end
        chk("t1_cap_cs", {31'b0, mem_chipselect}, 0);
        @(negedge clk);
        chk("t1_chk_valid", {31'b0, desc_valid}, 0);
        @(negedge clk);
        chk("t1_valid", {31'b0, desc_valid}, 1);
        chk("t1_src", desc_src, 32'h1000);
        chk("t1_dst", desc_dst, 32'h2000);
        chk("t1_len", {16'b0, desc_len}, 32'h40);
        @(negedge clk);
        chk("t1_wait", {30'b0, busy, desc_valid}, 32'b10);
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
        chk("t1_wb", {27'b0, mem_chipselect, mem_write, mem_byteenable[3:1]},
            32'b11100);
        chk("t1_wb_be", {28'b0, mem_byteenable}, 32'h8);
        chk("t1_wb_addr", {21'b0, mem_address}, 32'h12);
        chk("t1_wb_data", mem_writedata, 32'h4000_0000);
        @(negedge clk);
        chk("t1_done", {30'b0, chain_done, chain_stopped}, 32'b10);
        chk("t1_count", {16'b0, desc_count}, 1);
        chk("t1_mem", mem[11'h012], 32'h4000_0040);
        @(negedge clk);
        chk("t1_idle", {30'b0, busy, chain_done}, 0);

        // Two-descriptor chain wrapping past the top of memory
        f0 = fcnt;
        start = 1'b1; start_ptr = 11'h040;
        @(negedge clk);
        start = 1'b0;
        serve(32'hA, 1'b0);
        serve(32'hC, 1'b0);
        wait_for("t2_chain_done", 1'b1);
        chk("t2_stopped", {31'b0, chain_stopped}, 0);
        chk("t2_count", {16'b0, desc_count}, 2);
        chk("t2_nreads", fcnt - f0, 8);
        chk("t2_fa4", {21'b0, fa[(f0 + 4) % 64]}, 32'h7FE);
        chk("t2_fa5", {21'b0, fa[(f0 + 5) % 64]}, 32'h7FF);
        chk("t2_fa6", {21'b0, fa[(f0 + 6) % 64]}, 32'h000);
        chk("t2_fa7", {21'b0, fa[(f0 + 7) % 64]}, 32'h001);
        @(negedge clk);

        // Unowned descriptor stops the chain
        w0 = wr_count; v0 = valid_cnt;
        start = 1'b1; start_ptr = 11'h050;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t3_done", {30'b0, chain_done, chain_stopped}, 32'b11);
        chk("t3_count", {16'b0, desc_count}, 0);
        @(negedge clk);
        chk("t3_idle", {31'b0, busy}, 0);
        chk("t3_nowrite", wr_count - w0, 0);
        chk("t3_novalid", valid_cnt - v0, 0);

        // Back-pressure, ignored start while busy, error writeback
        desc_ready = 1'b0;
        start = 1'b1; start_ptr = 11'h060;
        @(negedge clk);
        start = 1'b0;
        wait_for("t4_valid", 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold", {31'b0, desc_valid}, 1);
            chk("t4_payload", desc_src ^ desc_dst ^ {16'b0, desc_len},
                32'h1111_2222 ^ 32'h3333_4444 ^ 32'h1234);
            @(negedge clk);
        end
        desc_ready = 1'b1;
        @(negedge clk);
        chk("t4_xfer", {31'b0, desc_valid}, 0);
        start = 1'b1; start_ptr = 11'h100;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy", {31'b0, busy}, 1);
        dma_done = 1'b1; dma_error = 1'b1;
        @(negedge clk);
        dma_done = 1'b0; dma_error = 1'b0;
        chk("t4_wb_addr", {21'b0, mem_address}, 32'h62);
        chk("t4_wb_data", mem_writedata, 32'h6000_0000);
        @(negedge clk);
        chk("t4_done", {30'b0, chain_done, chain_stopped}, 32'b10);
        chk("t4_count", {16'b0, desc_count}, 1);
        chk("t4_mem", mem[11'h062], 32'h6000_1234);
        @(negedge clk);

        // Reset during the second descriptor's WAIT_DONE
        load(11'h042, 32'h8000_0008);
        load(11'h000, 32'hC000_0004);
        start = 1'b1; start_ptr = 11'h040;
        @(negedge clk);
        start = 1'b0;
        serve(32'hA, 1'b0);
        wait_for("t5_valid2", 1'b0);
        @(negedge clk);
        chk("t5_pre_count", {16'b0, desc_count}, 1);
        w0 = wr_count;
        reset = 1'b1; start = 1'b1; start_ptr = 11'h010;
        @(negedge clk);
        chk("t5_busy", {31'b0, busy}, 0);
        chk("t5_count", {16'b0, desc_count}, 0);
        chk("t5_cs_valid", {30'b0, mem_chipselect, desc_valid}, 0);
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_idle", {31'b0, busy}, 0);
        chk("t5_nowrite", wr_count - w0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
